// File: rtl/weight_ctrl_pkg.sv
// Shared types and constants for the weight local-memory sequencer.
package weight_ctrl_pkg;

    localparam int MAX_WEIGHTS = 2000;

    localparam logic [4:0] MODE_G3 = 5'd1;
    localparam logic [4:0] MODE_G8 = 5'd2;

    localparam int GRP3_SIZE = 3;
    localparam int GRP8_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        LFIN = 2'd2,
        READ = 2'd3
    } state_t;

endpackage

// File: rtl/weight_mem_ctrl.sv
// Weight local-memory sequencer: streams loader beats into consecutive
// addresses, then issues grouped (3 or 8 weight) reads under valid/ready.
module weight_mem_ctrl
    import weight_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] load_count,
    input  logic              wdata_valid,
    input  logic [15:0]       wdata,
    output logic              wdata_ready,
    input  logic              start_read,
    input  logic [4:0]        read_mode,
    input  logic [ADDR_W-1:0] read_groups,
    output logic              mem_write_signal,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [15:0]       mem_write_data,
    output logic              mem_read_signal,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [4:0]        mem_buffer_sel,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              load_done,
    output logic              read_done,
    output logic              busy,
    output logic              err,
    output state_t            dbg_state
);

    // Handshakes: a beat/group transfers on a cycle where valid && ready are
    // both high at the rising edge; valid never depends on ready.

    state_t              state;
    logic [ADDR_W-1:0]   load_cnt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_groups;
    logic [ADDR_W-1:0]   rd_idx;
    logic [4:0]          rd_mode;
    logic                loaded;

    logic [2*ADDR_W-1:0] need_words;
    logic                load_ok;
    logic                read_ok;
    logic                last_group;

    // Double-width product so a huge group count cannot wrap past the check.
    always_comb begin
        need_words = {{ADDR_W{1'b0}}, read_groups} *
                     ((read_mode == MODE_G8) ? (2*ADDR_W)'(GRP8_SIZE)
                                             : (2*ADDR_W)'(GRP3_SIZE));
        load_ok    = (load_count != '0) && (load_count <= ADDR_W'(MAX_WEIGHTS));
        read_ok    = loaded
                     && ((read_mode == MODE_G3) || (read_mode == MODE_G8))
                     && (read_groups != '0)
                     && (need_words <= {{ADDR_W{1'b0}}, load_cnt});
        last_group = (rd_idx == rd_groups - ADDR_W'(1));
    end

    assign wdata_ready     = (state == LOAD);
    assign rd_valid        = (state == READ);
    assign mem_read_signal = rd_valid;
    assign mem_read_addr   = rd_valid ? rd_idx : '0;
    assign mem_buffer_sel  = rd_valid ? rd_mode : '0;
    assign read_done       = rd_valid && rd_ready && last_group;
    assign busy            = (state != IDLE);
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            load_cnt         <= '0;
            wr_ptr           <= '0;
            rd_groups        <= '0;
            rd_idx           <= '0;
            rd_mode          <= '0;
            loaded           <= 1'b0;
            err              <= 1'b0;
            mem_write_signal <= 1'b0;
            mem_write_addr   <= '0;
            mem_write_data   <= '0;
            load_done        <= 1'b0;
        end else begin
            mem_write_signal <= 1'b0;
            load_done        <= 1'b0;
            case (state)
                IDLE: begin
                    // A load request always takes priority over a read request.
                    if (start_load) begin
                        loaded <= 1'b0;
                        if (load_ok) begin
                            load_cnt <= load_count;
                            wr_ptr   <= '0;
                            state    <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (start_read) begin
                        if (read_ok) begin
                            rd_mode   <= read_mode;
                            rd_groups <= read_groups;
                            rd_idx    <= '0;
                            state     <= READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (wdata_valid) begin
                        mem_write_signal <= 1'b1;
                        mem_write_addr   <= wr_ptr;
                        mem_write_data   <= wdata;
                        if (wr_ptr == load_cnt - ADDR_W'(1)) begin
                            load_done <= 1'b1;
                            loaded    <= 1'b1;
                            state     <= LFIN;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                LFIN: begin
                    state <= IDLE;
                end
                READ: begin
                    if (rd_ready) begin
                        if (last_group) begin
                            state <= IDLE;
                        end else begin
                            rd_idx <= rd_idx + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Bench for weight_mem_ctrl: directed scenarios plus random traffic checked
// every cycle against a behavioural model of the sequencer.
module tb_weight_mem_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_LFIN = 2;
    localparam int S_READ = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_load = 1'b0;
    logic [15:0] load_count = '0;
    logic        wdata_valid = 1'b0;
    logic [15:0] wdata = '0;
    logic        wdata_ready;
    logic        start_read = 1'b0;
    logic [4:0]  read_mode = '0;
    logic [15:0] read_groups = '0;
    logic        mem_write_signal;
    logic [15:0] mem_write_addr;
    logic [15:0] mem_write_data;
    logic        mem_read_signal;
    logic [15:0] mem_read_addr;
    logic [4:0]  mem_buffer_sel;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        load_done;
    logic        read_done;
    logic        busy;
    logic        err;
    logic [1:0]  dbg_state;

    weight_mem_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .start_load(start_load), .load_count(load_count),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .start_read(start_read), .read_mode(read_mode), .read_groups(read_groups),
        .mem_write_signal(mem_write_signal), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_signal(mem_read_signal),
        .mem_read_addr(mem_read_addr), .mem_buffer_sel(mem_buffer_sel),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .load_done(load_done), .read_done(read_done),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_state = S_IDLE;
    int     m_cnt = 0, m_taken = 0;
    int     m_loaded = 0, m_loaded_cnt = 0;
    int     m_mode = 0, m_groups = 0, m_acc = 0;
    int     m_err = 0;
    longint m_need;
    logic   e_wsig = 1'b0, e_ldone = 1'b0;
    int     e_waddr = 0, e_wdata = 0;

    always @(posedge clk) begin
        e_wsig  = 1'b0;
        e_ldone = 1'b0;
        if (rst) begin
            m_state  = S_IDLE;
            m_loaded = 0;
            m_err    = 0;
            m_acc    = 0;
        end else begin
            case (m_state)
                S_IDLE: begin
                    if (start_load) begin
                        m_loaded = 0;
                        if (load_count >= 1 && load_count <= 2000) begin
                            m_cnt   = int'(load_count);
                            m_taken = 0;
                            m_state = S_LOAD;
                        end else begin
                            m_err = 1;
                        end
                    end else if (start_read) begin
                        m_need = longint'(read_groups) * ((read_mode == 5'd2) ? 8 : 3);
                        if (m_loaded == 1 && (read_mode == 5'd1 || read_mode == 5'd2)
                            && read_groups >= 1 && m_need <= longint'(m_loaded_cnt)) begin
                            m_mode   = int'(read_mode);
                            m_groups = int'(read_groups);
                            m_acc    = 0;
                            m_state  = S_READ;
                        end else begin
                            m_err = 1;
                        end
                    end
                end
                S_LOAD: begin
                    if (wdata_valid) begin
                        e_wsig  = 1'b1;
                        e_waddr = m_taken;
                        e_wdata = int'(wdata);
                        m_taken++;
                        if (m_taken == m_cnt) begin
                            e_ldone = 1'b1;
                            m_state = S_LFIN;
                        end
                    end
                end
                S_LFIN: begin
                    m_loaded     = 1;
                    m_loaded_cnt = m_cnt;
                    m_state      = S_IDLE;
                end
                default: begin
                    if (rd_ready) begin
                        if (m_acc == m_groups - 1) m_state = S_IDLE;
                        else m_acc++;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", dbg_state, m_state);
            chk("busy", busy, m_state != S_IDLE);
            chk("wdata_ready", wdata_ready, m_state == S_LOAD);
            chk("rd_valid", rd_valid, m_state == S_READ);
            chk("mem_read_signal", mem_read_signal, m_state == S_READ);
            chk("mem_read_addr", mem_read_addr, (m_state == S_READ) ? m_acc : 0);
            chk("mem_buffer_sel", mem_buffer_sel, (m_state == S_READ) ? m_mode : 0);
            chk("read_done", read_done,
                (m_state == S_READ) && rd_ready && (m_acc == m_groups - 1));
            chk("err", err, m_err);
            chk("mem_write_signal", mem_write_signal, e_wsig);
            chk("load_done", load_done, e_ldone);
            if (e_wsig) begin
                chk("mem_write_addr", mem_write_addr, e_waddr);
                chk("mem_write_data", mem_write_data, e_wdata);
            end
        end
    end

    // ---------------- write / read logs for directed checks ----------------
    int wl_cyc[$], wl_addr[$], wl_data[$], wl_ld[$];
    int rl_addr[$], rl_done[$];

    always @(negedge clk) begin
        if (mem_write_signal) begin
            wl_cyc.push_back(cyc);
            wl_addr.push_back(int'(mem_write_addr));
            wl_data.push_back(int'(mem_write_data));
            wl_ld.push_back(int'(load_done));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start_load = 1'b0; start_read = 1'b0;
        wdata_valid = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_load(input int n, input int vpct, input int base, input bit with_read,
                            output int st1, output int err1);
        int  hs = 0;
        bit  done = 1'b0;
        st1 = -1;
        err1 = -1;
        @(posedge clk); #1;
        start_load  = 1'b1;
        load_count  = 16'(n);
        start_read  = with_read;
        read_mode   = 5'd1;
        read_groups = 16'd1;
        @(posedge clk); #1;
        start_load = 1'b0;
        start_read = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            wdata_valid = ($urandom_range(99) < vpct);
            wdata       = 16'(base + hs);
            @(negedge clk);
            if (c == 0) begin
                st1  = int'(dbg_state);
                err1 = int'(err);
            end
            if (wdata_valid && wdata_ready) hs++;
            if (!busy) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        wdata_valid = 1'b0;
        chk("load_finished", done, 1);
    endtask

    task automatic run_read(input int mode, input int groups, input logic [7:0] pat,
                            input int pat_len, input int rpct);
        bit done = 1'b0;
        rl_addr.delete();
        rl_done.delete();
        @(posedge clk); #1;
        start_read  = 1'b1;
        read_mode   = 5'(mode);
        read_groups = 16'(groups);
        rd_ready    = 1'b0;
        @(posedge clk); #1;
        start_read = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            rd_ready = (c < pat_len) ? pat[c] : ($urandom_range(99) < rpct);
            @(negedge clk);
            if (rd_valid) begin
                rl_addr.push_back(int'(mem_read_addr));
                rl_done.push_back(int'(read_done));
            end
            if (!busy) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        rd_ready = 1'b0;
        chk("read_finished", done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st1, err1, hs;

        @(posedge clk);
        chk_en = 1'b1;
        do_reset();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wsig", mem_write_signal, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_state", dbg_state, 0);

        // 5 weights, valid held high
        wl_cyc.delete(); wl_addr.delete(); wl_data.delete(); wl_ld.delete();
        run_load(5, 100, 'h11, 1'b0, st1, err1);
        chk("t1_nwrites", wl_addr.size(), 5);
        for (int i = 0; i < wl_addr.size() && i < 5; i++) begin
            chk("t1_addr", wl_addr[i], i);
            chk("t1_data", wl_data[i], 'h11 + i);
            chk("t1_consecutive", wl_cyc[i] - wl_cyc[0], i);
            chk("t1_load_done", wl_ld[i], (i == 4) ? 1 : 0);
        end
        @(negedge clk);
        chk("t1_busy_after", busy, 0);

        // 24 weights, then 3 groups of 8 with rd_ready 1,0,1,1
        run_load(24, 70, 'h200, 1'b0, st1, err1);
        chk("model_loaded_cnt", m_loaded_cnt, 24);
        run_read(2, 3, 8'b0000_1101, 4, 50);
        chk("t2_nvalid", rl_addr.size(), 4);
        for (int i = 0; i < rl_addr.size() && i < 4; i++) begin
            chk("t2_addr", rl_addr[i], (i == 0) ? 0 : (i == 3) ? 2 : 1);
            chk("t2_read_done", rl_done[i], (i == 3) ? 1 : 0);
        end
        chk("t2_err", err, 0);

        // 9 weights, 4 groups of 3 -> 12 > 9 is illegal
        run_load(9, 100, 'h300, 1'b0, st1, err1);
        run_read(1, 4, 8'h00, 0, 50);
        chk("t3_err", err, 1);
        chk("model_err_t3", m_err, 1);
        chk("t3_no_valid", rl_addr.size(), 0);
        chk("t3_state", dbg_state, 0);

        // read before any load; oversized load
        do_reset();
        run_read(1, 1, 8'h00, 0, 50);
        chk("t4_read_err", err, 1);
        chk("t4_read_state", dbg_state, 0);
        do_reset();
        run_load(2001, 100, 0, 1'b0, st1, err1);
        chk("t4_load_err", err1, 1);
        chk("t4_load_state", st1, 0);

        // rst after 3 of 8 beats
        do_reset();
        @(posedge clk); #1;
        start_load = 1'b1; load_count = 16'd8; wdata_valid = 1'b1; wdata = 16'h0abc;
        @(posedge clk); #1;
        start_load = 1'b0;
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            if (wdata_valid && wdata_ready) hs++;
            if (hs < 3) begin
                @(posedge clk); #1;
            end
        end
        chk("t5_beats", hs, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wdata_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_wdata_ready", wdata_ready, 0);
        chk("t5_wsig", mem_write_signal, 0);
        chk("t5_waddr", mem_write_addr, 0);
        chk("t5_wdata", mem_write_data, 0);
        chk("t5_load_done", load_done, 0);
        chk("t5_rd_valid", rd_valid, 0);
        chk("t5_err", err, 0);
        run_read(1, 1, 8'h00, 0, 50);
        chk("t5_read_err", err, 1);

        // simultaneous start_load and start_read
        do_reset();
        run_load(4, 100, 'h40, 1'b1, st1, err1);
        chk("t6_state", st1, 1);
        chk("t6_err", err1, 0);
        chk("t6_err_end", err, 0);
        run_read(1, 1, 8'h01, 1, 50);
        chk("t6_read_n", rl_addr.size(), 1);

        // random traffic
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(299) == 0);
            start_load = ($urandom_range(99) < 3);
            case ($urandom_range(9))
                0:       load_count = 16'd0;
                1:       load_count = 16'($urandom_range(2010, 1990));
                default: load_count = 16'($urandom_range(40, 1));
            endcase
            start_read  = ($urandom_range(99) < 8);
            read_mode   = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(3));
            read_groups = 16'($urandom_range(6));
            wdata_valid = ($urandom_range(99) < 70);
            wdata       = 16'($urandom);
            rd_ready    = ($urandom_range(99) < 60);
        end
        @(posedge clk); #1;
        rst = 1'b0; start_load = 1'b0; start_read = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_mem_ctrl.md
# weight_mem_ctrl

Sequencer for the on-chip weight local memory. It accepts a stream of 16-bit weights from the upstream loader and writes them into consecutive memory addresses. It then drives grouped read requests (3-weight or 8-weight groups) toward the convolution/FC buffer using a valid/ready handshake. It sits between the DMA/loader front end and the weight memory, and owns every write/read control pin of that memory.

## Interface
- MAX_WEIGHTS, 2000: weight memory depth in 16-bit words.
- ADDR_W, 16: address and count width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_load  in  1  one-cycle pulse in IDLE: begin a load of load_count weights.
- load_count  in  ADDR_W  number of weights to load; sampled on start_load.
- wdata_valid  in  1  upstream weight beat valid.
- wdata  in  16  upstream weight value.
- wdata_ready  out  1  high only in LOAD.
- start_read  in  1  one-cycle pulse in IDLE: begin a grouped read.
- read_mode  in  5  1 = 3-weight groups, 2 = 8-weight groups; sampled on start_read.
- read_groups  in  ADDR_W  number of groups to read; sampled on start_read.
- mem_write_signal / mem_write_addr / mem_write_data  out  1/ADDR_W/16  memory write port, registered.
- mem_read_signal  out  1  memory read enable; equals rd_valid.
- mem_read_addr  out  ADDR_W  group index.
- mem_buffer_sel  out  5  latched read_mode.
- rd_valid  out  1  group on memory read data is valid.
- rd_ready  in  1  consumer accepts the current group.
- load_done, read_done  out  1  one-cycle completion pulses.
- busy  out  1  state is not IDLE.
- err  out  1  sticky; cleared only by rst.

All outputs reset to 0. State resets to IDLE and the loaded flag clears.

## Operation
- States: IDLE, LOAD, LFIN, READ.
- IDLE, start_load with 1 ≤ load_count ≤ MAX_WEIGHTS: latch the count, clear the write pointer, go to LOAD. A count of 0 or above MAX_WEIGHTS sets err and the FSM stays in IDLE.
- LOAD: wdata_ready=1. On each wdata_valid&&wdata_ready, the beat is registered to the write port at address = pointer, and the pointer increments. After the beat with pointer = count−1, go to LFIN.
- LFIN: one cycle in which the final write is presented. load_done=1, loaded flag set, go to IDLE.
- IDLE, start_read: the request is legal only if loaded=1, read_mode ∈ {1,2}, read_groups ≥ 1, and groups×(3 or 8) ≤ the loaded count.
  - Illegal: set err and stay in IDLE.
  - Legal: latch mode and groups, clear the index, go to READ.
- READ: rd_valid=mem_read_signal=1, mem_read_addr=index, mem_buffer_sel=mode. On rd_valid&&rd_ready the index increments. Acceptance of the last group pulses read_done in the same cycle, and the next state is IDLE.
- Simultaneous start_load and start_read in IDLE: the load wins and the read is dropped without setting err.
- start_* outside IDLE: ignored, no err.
- The loaded flag stays set across reads and is cleared only by a new start_load or by rst.
- Arithmetic: the group×size product is computed at 2×ADDR_W bits, so it cannot wrap. The pointer and index never exceed count−1 or groups−1.

## Timing
- Write latency: handshake in cycle N → mem_write_signal/addr/data valid in cycle N+1 for exactly one cycle. Back-to-back beats give back-to-back writes.
- load_done is asserted in the same cycle as the final mem_write_signal.
- Read: memory read data is combinational from the address, so the group is valid in the same cycle rd_valid is high. The address holds while rd_ready=0.
- rst mid-LOAD or mid-READ: next cycle is IDLE and all outputs are 0. A pending registered write is squashed.
- One idle cycle is required between load_done and a start_read that the controller will accept.

## Structure
- Package weight_ctrl_pkg holds:
  - state enum {IDLE, LOAD, LFIN, READ};
  - mode constants MODE_G3=5'd1 and MODE_G8=5'd2;
  - group-size constants 3 and 8;
  - MAX_WEIGHTS.
- Single module with no sub-modules. It is instantiated next to the weight memory in the layer top.

## Test plan
- Load 5 weights 0x0011..0x0015 with wdata_valid held high → writes to addresses 0..4 in consecutive cycles, load_done coinciding with the address-4 write, then busy=0.
- Load 24 weights, then read in mode 2 with 3 groups and rd_ready toggling 1,0,1,1 → mem_read_addr sequence 0,1,1,2; read_done on acceptance of group 2.
- Load 9 weights, then read in mode 1 with groups=4 → err=1, state stays IDLE, no read_valid asserted.
- start_read before any load, and load_count=2001 → err set each time; FSM remains in IDLE.
- Assert rst during LOAD after 3 of 8 beats → next cycle all outputs 0; a following start_read errs because loaded was cleared.
- start_load and start_read asserted in the same IDLE cycle → LOAD entered, no err, no read issued.
